// File: rtl/paral_serial_pkg.sv
// Shared constants and state encoding for the clk8f parallel-to-serial transmitter.
package paral_serial_pkg;

    localparam logic [7:0]  IDLE_WORD_DEF = 8'hBC;  // K28.5 comma
    localparam int unsigned BIT_CNT_W     = 3;

    typedef enum logic {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/fifo_2x8.sv
// Two-entry, 8-bit FIFO. head always presents the oldest word.
module fifo_2x8 (
    input  logic       clk8f,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] head,
    output logic [1:0] count
);

    logic [7:0] mem0;
    logic [7:0] mem1;
    logic       do_pop;

    assign head   = mem0;
    assign do_pop = pop && (count != 2'd0);

    always_ff @(posedge clk8f) begin
        if (reset) begin
            mem0  <= '0;
            mem1  <= '0;
            count <= '0;
        end else begin
            if (push && do_pop) begin
                // Push alongside a pop only reaches here with one entry, so the new word becomes head.
                mem0 <= din;
            end else if (do_pop) begin
                mem0  <= mem1;
                count <= count - 2'd1;
            end else if (push) begin
                if (count == 2'd0) begin
                    mem0 <= din;
                end else begin
                    mem1 <= din;
                end
                count <= count + 2'd1;
            end
        end
    end

endmodule

// File: rtl/paral_serial.sv
// Serializes buffered 8-bit words MSB first, one bit per clk8f; idle words fill sync and gaps.
module paral_serial
    import paral_serial_pkg::*;
#(
    parameter logic [7:0]  IDLE_WORD  = IDLE_WORD_DEF,
    parameter int unsigned SYNC_WORDS = 4
) (
    input  logic       clk8f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       data_out,
    output logic       frame_start,
    output logic       is_data,
    output logic       sync_done
);

    localparam logic [3:0] SYNC_LAST = 4'(SYNC_WORDS);

    state_t               state;
    state_t               state_next;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [3:0]           sync_cnt;
    logic [3:0]           sync_cnt_next;
    logic [6:0]           shreg;
    logic [7:0]           fifo_head;
    logic [1:0]           fifo_count;
    logic [7:0]           load_word;
    logic                 boundary;
    logic                 go_active;
    logic                 push;
    logic                 pop;

    fifo_2x8 u_fifo (
        .clk8f (clk8f),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (data_in),
        .head  (fifo_head),
        .count (fifo_count)
    );

    assign ready_out = !reset && (fifo_count < 2'd2);
    assign sync_done = (state == ACTIVE);

    always_comb begin
        state_next    = state;
        sync_cnt_next = sync_cnt;
        boundary      = (bit_cnt == '0);
        go_active     = (state == SYNC) && boundary && (sync_cnt == SYNC_LAST);
        push          = valid_in && ready_out;
        // The boundary that ends sync may already carry data.
        pop           = boundary && ((state == ACTIVE) || go_active) && (fifo_count != 2'd0);
        load_word     = pop ? fifo_head : IDLE_WORD;
        if (go_active) begin
            state_next = ACTIVE;
        end else if ((state == SYNC) && boundary) begin
            sync_cnt_next = sync_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk8f) begin
        if (reset) begin
            state       <= SYNC;
            bit_cnt     <= '0;
            sync_cnt    <= '0;
            shreg       <= '0;
            data_out    <= 1'b0;
            frame_start <= 1'b0;
            is_data     <= 1'b0;
        end else begin
            state    <= state_next;
            sync_cnt <= sync_cnt_next;
            bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
            if (boundary) begin
                data_out    <= load_word[7];
                shreg       <= load_word[6:0];
                frame_start <= 1'b1;
                is_data     <= pop;
            end else begin
                data_out    <= shreg[6];
                shreg       <= {shreg[5:0], 1'b0};
                frame_start <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_paral_serial.sv
// Directed and random stimulus for paral_serial against a queue-based word/edge model.
module tb_paral_serial;

    localparam logic [7:0] IDLE   = 8'hBC;
    localparam int         NSYNC  = 4;

    logic       clk8f = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic       ready_out;
    logic       data_out;
    logic       frame_start;
    logic       is_data;
    logic       sync_done;

    int checks = 0;
    int errors = 0;

    // Model: edge index since reset release, words accepted but not yet sent, word on the line.
    int         e = 0;
    logic [7:0] q[$];
    logic [7:0] cur_word = 8'h00;
    logic       cur_isd = 1'b0;
    logic       accepted = 1'b0;
    logic       exp_do, exp_fs, exp_id, exp_sd, exp_rdy;

    paral_serial #(.IDLE_WORD(8'hBC), .SYNC_WORDS(4)) dut (
        .clk8f       (clk8f),
        .reset       (reset),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .data_out    (data_out),
        .frame_start (frame_start),
        .is_data     (is_data),
        .sync_done   (sync_done)
    );

    always #5 clk8f = ~clk8f;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at model edge %0d: observed %b expected %b", tag, e, obs, exp);
        end
    endtask

    task automatic tick();
        int bitpos;
        accepted = 1'b0;
        if (reset) begin
            q.delete();
            e      = 0;
            exp_do = 1'b0;
            exp_fs = 1'b0;
            exp_id = 1'b0;
            exp_sd = 1'b0;
        end else begin
            accepted = valid_in && (q.size() < 2);
            if (e % 8 == 0) begin
                if (e >= 8 * NSYNC && q.size() > 0) begin
                    cur_word = q.pop_front();
                    cur_isd  = 1'b1;
                end else begin
                    cur_word = IDLE;
                    cur_isd  = 1'b0;
                end
            end
            bitpos = 7 - (e % 8);
            exp_do = cur_word[bitpos];
            exp_fs = (e % 8 == 0);
            exp_id = cur_isd;
            exp_sd = (e >= 8 * NSYNC);
            if (accepted) q.push_back(data_in);
            e++;
        end
        @(posedge clk8f);
        #1;
        exp_rdy = !reset && (q.size() < 2);
        chk("data_out", data_out, exp_do);
        chk("frame_start", frame_start, exp_fs);
        chk("is_data", is_data, exp_id);
        chk("sync_done", sync_done, exp_sd);
        chk("ready_out", ready_out, exp_rdy);
    endtask

    task automatic idle_ticks(input int n);
        valid_in = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance with valid_in low until the next edge to be taken has the given phase.
    task automatic wait_phase(input int ph);
        valid_in = 1'b0;
        for (int i = 0; i < 16 && (e % 8) != ph; i++) tick();
        chk("wait_phase_reached", (e % 8) == ph, 1'b1);
    endtask

    task automatic push_one(input logic [7:0] d);
        data_in  = d;
        valid_in = 1'b1;
        tick();
        chk("push_accepted", accepted, 1'b1);
        valid_in = 1'b0;
    endtask

    initial begin
        logic [7:0] nxt;
        bit         hit;

        // Reset held three edges, then sync with one word queued during SYNC.
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b0;
        idle_ticks(20);
        push_one(8'hA5);
        idle_ticks(27);

        // Back-to-back stream into a full buffer.
        nxt      = 8'h01;
        data_in  = nxt;
        valid_in = 1'b1;
        for (int i = 0; i < 48; i++) begin
            tick();
            if (accepted) begin
                nxt++;
                data_in = nxt;
            end
        end
        idle_ticks(40);

        // Same-edge push and pop with a single buffered word.
        wait_phase(3);
        push_one(8'h11);
        wait_phase(0);
        push_one(8'h22);
        idle_ticks(20);

        // Minimum latency: accept on the last bit edge, MSB on the next boundary.
        wait_phase(7);
        push_one(8'hF0);
        idle_ticks(12);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            valid_in = ($urandom_range(0, 3) != 0);
            data_in  = 8'($urandom);
            tick();
        end

        // Reset in the middle of a data word with the buffer full.
        hit      = 1'b0;
        valid_in = 1'b1;
        for (int i = 0; i < 200 && !hit; i++) begin
            data_in = 8'($urandom);
            if (q.size() == 2 && cur_isd && (e % 8) == 4) hit = 1'b1;
            else tick();
        end
        chk("midword_condition_reached", hit, 1'b1);
        reset    = 1'b1;
        valid_in = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        idle_ticks(48);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within the time bound");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/paral_serial.md
# paral_serial

Parallel-to-serial transmitter in the clk8f domain, sitting downstream of the clock generator, at the tail of the transmit path. Accepts 8-bit words through a valid/ready handshake into a 2-entry buffer and shifts each word out MSB first, one bit per clk8f cycle, so one word occupies exactly one clkf period. After reset it sends SYNC_WORDS idle/comma words before carrying data. Whenever the buffer is empty it inserts the idle word, so the serial line never stalls.

## Interface
- IDLE_WORD, 8'hBC: comma/idle symbol sent during sync and when no data is available.
- SYNC_WORDS, 4: number of idle words sent after reset before data may be carried; legal range 1..15.

- clk8f  input  1  serial bit clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  8  parallel word from upstream.
- valid_in  input  1  data_in valid.
- ready_out  output  1  buffer can accept a word; a transfer occurs on an edge where valid_in && ready_out.
- data_out  output  1  serial bit, registered.
- frame_start  output  1  high while data_out carries bit 7 of a word.
- is_data  output  1  high for all 8 bits of a word popped from the buffer; low for idle words.
- sync_done  output  1  high once state is ACTIVE.

## Operation
- State machine: SYNC -> ACTIVE only. In SYNC every word is IDLE_WORD. The SYNC to ACTIVE transition happens at the word boundary after SYNC_WORDS idle words. ACTIVE holds until reset.
- A 3-bit bit counter counts 0..7 and wraps 7 -> 0. A word boundary is any edge on which the counter is 0.
- Load decision at each word boundary:
  - In ACTIVE with the buffer non-empty: pop the head into the shift register. is_data=1 for that word.
  - Otherwise (SYNC, or buffer empty): load IDLE_WORD. is_data=0.
- Output per edge:
  - Boundary edge: data_out=word[7] and frame_start=1.
  - Following 7 edges: word[6] down to word[0], with frame_start=0.
- Buffer is 2-entry FIFO order, accepting in both states.
  - ready_out = !reset && (count < 2), taken from the registered count.
  - Full: ready_out=0. A push is not accepted even if a pop occurs on the same edge.
  - Push and pop on the same edge with count=1: count stays 1, and the pushed word becomes head.
  - Pop with count=0 cannot occur; IDLE_WORD is loaded instead.
- Bytes are never dropped, duplicated or reordered.

## Timing
- Reset values, applied on any edge with reset=1, including mid-word:
  - data_out=0, frame_start=0, is_data=0, sync_done=0.
  - Bit counter 0, sync counter 0, FIFO flushed (count 0), state SYNC.
  - ready_out=0 while reset is high.
  - A partially sent word is abandoned.
- First edge with reset=0 is edge 0, a word boundary: data_out=IDLE_WORD[7]=1, frame_start=1.
- Word boundaries fall on edges 0, 8, 16, …
- sync_done goes to 1 on edge 8*SYNC_WORDS, the first boundary that may carry data.
- Latency: a word accepted on edge k is popped at the first boundary edge strictly after k, provided state is ACTIVE and it is the buffer head.
  - Minimum latency is 1 cycle: accept on edge 8n-1, MSB out on edge 8n.
- Sustained throughput is 1 word per 8 cycles. Upstream bursts of up to 2 words are absorbed.

## Structure
- Shared package `paral_serial_pkg`: IDLE_WORD default (K28.5, 8'hBC), state encoding (SYNC=0, ACTIVE=1), bit-counter width 3.
- Sub-module `fifo_2x8`: 2-entry × 8-bit FIFO with push, pop, head, count[1:0] and synchronous active-high reset.
- Top level holds the bit counter, sync counter, state register, shift register and output registers.

## Test plan
- **Reset/sync:** hold reset for 3 edges, release, valid_in=0.
  - data_out repeats 10111100 every 8 edges with frame_start at edges 0, 8, …
  - sync_done rises at edge 32.
  - is_data stays 0.
- **Single word:** push 8'hA5 during SYNC.
  - Held until edge 32, then bits 1,0,1,0,0,1,0,1 on edges 32..39 with is_data=1.
  - Edge 40 returns to 8'hBC.
- **Back-to-back and full buffer:** in ACTIVE with valid_in=1 continuously, words 8'h01, 8'h02, 8'h03 …
  - ready_out drops after 2 accepts.
  - One word is accepted per 8 edges thereafter.
  - Serial stream shows 01, 02, 03 in order with no idle between them.
- **Same-edge push/pop:** count=1 (head 8'h11), push 8'h22 on a boundary edge.
  - 8'h11 is serialized and count stays 1.
  - 8'h22 follows at the next boundary.
- **Reset mid-word:** assert reset at bit 4 of a data word with 2 words buffered.
  - Next edge: all outputs are at reset values.
  - After release: 4 idle words, and no buffered data ever appears.
- **Minimum latency:** in ACTIVE with the buffer empty, push 8'hF0 on edge 8n-1.
  - data_out=1 and is_data=1 on edge 8n.
